// File: rtl/screen_reader_if.sv
// Screen-memory read port plus the serialized pixel stream of the screen reader.
interface screen_reader_if #(
  parameter int unsigned ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] address;
  logic [15:0]           ram_data;
  logic                  pixel;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic                  line_start;
  logic                  frame_start;

  modport master (
    output address, pixel, pixel_valid, line_start, frame_start,
    input  ram_data, pixel_ready
  );

  modport slave (
    input  address, pixel, pixel_valid, line_start, frame_start,
    output ram_data, pixel_ready
  );
endinterface

// File: rtl/screen_reader.sv
// Scans screen memory in address order and serializes each word LSB-first
// onto a valid/ready pixel stream with line/frame start markers.
module screen_reader #(
  parameter int unsigned WORDS_PER_LINE = 32,
  parameter int unsigned LINES          = 256,
  parameter int unsigned ADDR_WIDTH     = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  screen_reader_if.master bus
);

  localparam int unsigned WORDS_PER_FRAME = WORDS_PER_LINE * LINES;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned WORD_W          = 16;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_W-1:0]       shift_q, shift_d;
  logic                    valid_q, valid_d;
  logic                    line_start_q, line_start_d;
  logic                    frame_start_q, frame_start_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      address_q     <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      valid_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      valid_q       <= valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    valid_d       = valid_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        // Markers are decided once per word from the stable fetch address.
        shift_d       = bus.ram_data;
        idx_d         = '0;
        valid_d       = 1'b1;
        line_start_d  = ((32'(address_q) % WORDS_PER_LINE) == 32'd0);
        frame_start_d = (address_q == '0);
        state_d       = SHIFT;
      end
      SHIFT: begin
        if (valid_q && bus.pixel_ready) begin
          shift_d       = shift_q >> 1;
          idx_d         = idx_q + IDX_W'(1);
          line_start_d  = 1'b0;
          frame_start_d = 1'b0;
          if (idx_q == IDX_W'(WORD_W - 1)) begin
            valid_d   = 1'b0;
            address_d = (address_q == ADDR_WIDTH'(WORDS_PER_FRAME - 1)) ?
                        '0 : address_q + ADDR_WIDTH'(1);
            state_d   = enable ? FETCH : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.address     = address_q;
  assign bus.pixel       = shift_q[0];
  assign bus.pixel_valid = valid_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule
